// File: rtl/uart_rx_sampler_if.sv
// Output side of the UART receive monitor: decoded word, error flags and
// overrun pulse, with a valid/ready handshake toward the consumer.
//
// Handshake: the master raises rx_valid with rx_data and the flags stable
// and holds them until a cycle where rx_valid && rx_ready, which is the
// transfer. rx_ready while rx_valid is low has no effect. overrun is a
// one-cycle pulse outside the handshake and is not qualified by rx_valid.
interface uart_rx_sampler_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 break_det;
    logic                 overrun;

    modport master (
        output rx_data, rx_valid, parity_err, frame_err, break_det, overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, parity_err, frame_err, break_det, overrun,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// Passive UART receive monitor. Synchronises the tapped line, decides each
// bit by a 3-sample mid-bit majority vote, checks parity/stop bits, detects
// break, and presents each word on a valid/ready holding register.
module uart_rx_sampler #(
    parameter int CLK_FREQ    = 100000000,
    parameter int BAUD_RATE   = 6250000,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    uart_rx_sampler_if.master    rx,
    output logic                 busy
);
    localparam int CPB = CLK_FREQ / BAUD_RATE;
    localparam int M   = (CPB - 1) / 2;
    localparam int CW  = $clog2(CPB);
    localparam int BW  = $clog2(DATA_BITS);

    localparam logic [CW-1:0] C_SMP0 = CW'(M - 1);
    localparam logic [CW-1:0] C_SMP1 = CW'(M);
    localparam logic [CW-1:0] C_DEC  = CW'(M + 1);
    localparam logic [CW-1:0] C_LAST = CW'(CPB - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
    localparam logic          S_LAST = 1'(STOP_BITS - 1);

    if (CPB < 8) begin : g_bad_cpb
        $error("uart_rx_sampler: CLK_FREQ/BAUD_RATE must be >= 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
        $error("uart_rx_sampler: DATA_BITS must be 5..9");
    end
    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_par
        $error("uart_rx_sampler: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_rx_sampler: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
    } state_t;

    logic                 sync1_q, rs_q, rs_prev_q, armed_q;
    logic [1:0]           fill_q;
    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic [BW-1:0]        bit_idx_q;
    logic                 stop_idx_q;
    logic                 s0_q, s1_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic                 par_q, zero_q, ferr_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q, parity_err_q, frame_err_q, break_det_q, overrun_q;

    logic start_edge, maj, at_decide, at_wrap, last_stop, deliver;
    logic ferr_fin, zero_fin, perr_fin;

    // Two-flop synchroniser plus start arming. The sync flops reset to 1,
    // which is not a real look at the line, so fill_q marks when rs_q holds
    // a genuine sample; only a genuine high arms start detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            rs_q      <= 1'b1;
            rs_prev_q <= 1'b1;
            fill_q    <= 2'b00;
            armed_q   <= 1'b0;
        end else begin
            sync1_q   <= rxd;
            rs_q      <= sync1_q;
            rs_prev_q <= rs_q;
            fill_q    <= {fill_q[0], 1'b1};
            if (rs_q && fill_q[1]) armed_q <= 1'b1;
        end
    end

    assign start_edge = armed_q & rs_prev_q & ~rs_q;
    assign maj        = (s0_q & s1_q) | (s0_q & rs_q) | (s1_q & rs_q);
    assign at_decide  = (cnt_q == C_DEC);
    assign at_wrap    = (cnt_q == C_LAST);
    assign last_stop  = (stop_idx_q == S_LAST);
    assign deliver    = (state_q == S_STOP) && at_decide && last_stop;
    assign ferr_fin   = ferr_q | ~maj;
    assign zero_fin   = zero_q & ~maj;
    // par_q holds the XOR of data and parity bit once the parity cell is done.
    assign perr_fin   = (PARITY_MODE == 1) ? ~par_q :
                        (PARITY_MODE == 2) ?  par_q : 1'b0;

    // Frame FSM, bit-cell counter, sampling, and the output holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            stop_idx_q   <= 1'b0;
            s0_q         <= 1'b1;
            s1_q         <= 1'b1;
            shreg_q      <= '0;
            par_q        <= 1'b0;
            zero_q       <= 1'b1;
            ferr_q       <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            break_det_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            if (state_q != S_IDLE && state_q != S_WAIT_HIGH) begin
                cnt_q <= at_wrap ? '0 : cnt_q + CW'(1);
                if (cnt_q == C_SMP0) s0_q <= rs_q;
                if (cnt_q == C_SMP1) s1_q <= rs_q;
            end

            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (start_edge) begin
                        state_q    <= S_START;
                        cnt_q      <= CW'(1);
                        bit_idx_q  <= '0;
                        stop_idx_q <= 1'b0;
                        par_q      <= 1'b0;
                        zero_q     <= 1'b1;
                        ferr_q     <= 1'b0;
                    end
                end
                S_START: begin
                    if (at_decide && maj) begin
                        state_q <= S_IDLE;    // false start: line went back high
                        cnt_q   <= '0;
                    end else if (at_wrap) begin
                        state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (at_decide) begin
                        shreg_q <= {maj, shreg_q[DATA_BITS-1:1]};
                        par_q   <= par_q ^ maj;
                        zero_q  <= zero_q & ~maj;
                    end
                    if (at_wrap) begin
                        if (bit_idx_q == B_LAST) begin
                            bit_idx_q <= '0;
                            state_q   <= (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + BW'(1);
                        end
                    end
                end
                S_PARITY: begin
                    if (at_decide) begin
                        par_q  <= par_q ^ maj;
                        zero_q <= zero_q & ~maj;
                    end
                    if (at_wrap) state_q <= S_STOP;
                end
                S_STOP: begin
                    if (at_decide) begin
                        ferr_q <= ferr_fin;
                        zero_q <= zero_fin;
                        if (last_stop) begin
                            // Leave mid-stop so a back-to-back start is seen.
                            state_q <= maj ? S_IDLE : S_WAIT_HIGH;
                            cnt_q   <= '0;
                        end
                    end
                    if (at_wrap && !last_stop) stop_idx_q <= 1'b1;
                end
                S_WAIT_HIGH: begin
                    cnt_q <= '0;
                    if (rs_q) state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                end
            endcase

            overrun_q <= 1'b0;
            if (deliver) begin
                if (!rx_valid_q || rx.rx_ready) begin
                    rx_data_q    <= shreg_q;
                    rx_valid_q   <= 1'b1;
                    parity_err_q <= perr_fin;
                    frame_err_q  <= ferr_fin;
                    break_det_q  <= zero_fin;
                end else begin
                    overrun_q    <= 1'b1;   // holding register full: drop new word
                end
            end else if (rx_valid_q && rx.rx_ready) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    assign rx.rx_data    = rx_data_q;
    assign rx.rx_valid   = rx_valid_q;
    assign rx.parity_err = parity_err_q;
    assign rx.frame_err  = frame_err_q;
    assign rx.break_det  = break_det_q;
    assign rx.overrun    = overrun_q;
    assign busy          = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler. Instance a is 8N1 (CPB=16), instance b
// is 8E1. Accepted words are logged as {break, frame, parity, data[7:0]}.
module tb_uart_rx_sampler;
    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst;
    logic rxd_a, rxd_b;
    logic busy_a, busy_b;

    int errors = 0;
    int checks = 0;

    logic [10:0] got_a[$];
    logic [10:0] got_b[$];
    int          vcnt_a = 0;
    int          ocnt_a = 0;

    uart_rx_sampler_if #(.DATA_BITS(8)) bus_a ();
    uart_rx_sampler_if #(.DATA_BITS(8)) bus_b ();

    uart_rx_sampler dut_a (
        .clk  (clk),
        .rst  (rst),
        .rxd  (rxd_a),
        .rx   (bus_a.master),
        .busy (busy_a)
    );

    uart_rx_sampler #(.PARITY_MODE(2)) dut_b (
        .clk  (clk),
        .rst  (rst),
        .rxd  (rxd_b),
        .rx   (bus_b.master),
        .busy (busy_b)
    );

    // clock / reset
    always #5 clk = ~clk;

    // output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (bus_a.rx_valid && bus_a.rx_ready)
            got_a.push_back({bus_a.break_det, bus_a.frame_err, bus_a.parity_err, bus_a.rx_data});
        if (bus_b.rx_valid && bus_b.rx_ready)
            got_b.push_back({bus_b.break_det, bus_b.frame_err, bus_b.parity_err, bus_b.rx_data});
        if (bus_a.rx_valid) vcnt_a++;
        if (bus_a.overrun)  ocnt_a++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // driver: hold a line level for n clocks, changes land 1ns after posedge
    task automatic drive(input bit sel, input logic val, input int n);
        if (sel) rxd_b = val; else rxd_a = val;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d, input bit par_en,
                              input logic par_bit);
        drive(sel, 1'b0, CPB);
        for (int i = 0; i < 8; i++) drive(sel, d[i], CPB);
        if (par_en) drive(sel, par_bit, CPB);
        drive(sel, 1'b1, CPB);
        drive(sel, 1'b1, CPB);
    endtask

    task automatic pop_word(input bit sel, input string tag, input logic [10:0] exp_v);
        int n;
        int sz;
        logic [10:0] r;
        n = 0;
        sz = sel ? got_b.size() : got_a.size();
        while (sz == 0 && n < 400) begin
            @(posedge clk);
            n++;
            sz = sel ? got_b.size() : got_a.size();
        end
        check({tag, "_avail"}, 32'(sz > 0), 32'd1);
        if (sz > 0) begin
            r = sel ? got_b.pop_front() : got_a.pop_front();
            check(tag, 32'(r), 32'(exp_v));
        end
    endtask

    initial begin
        int v0;
        int o0;
        logic [7:0] d;

        rst = 1'b1;
        rxd_a = 1'b1;
        rxd_b = 1'b1;
        bus_a.rx_ready = 1'b1;
        bus_b.rx_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(bus_a.rx_valid), 32'd0);
        check("rst_data", 32'(bus_a.rx_data), 32'd0);
        check("rst_flags", 32'({bus_a.break_det, bus_a.frame_err, bus_a.parity_err}), 32'd0);
        check("rst_overrun", 32'(bus_a.overrun), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        drive(0, 1'b1, 20);
        drive(1, 1'b1, 1);

        // 8N1 0xA5: busy until mid-stop, valid for exactly one cycle
        v0 = vcnt_a;
        d = 8'hA5;
        drive(0, 1'b0, CPB);
        for (int i = 0; i < 8; i++) drive(0, d[i], CPB);
        drive(0, 1'b1, 10);
        @(negedge clk);
        check("busy_before_midstop", 32'(busy_a), 32'd1);
        drive(0, 1'b1, 2);
        @(negedge clk);
        check("busy_after_midstop", 32'(busy_a), 32'd0);
        drive(0, 1'b1, 20);
        check("valid_one_cycle", 32'(vcnt_a - v0), 32'd1);
        pop_word(0, "word_a5", 11'h0A5);

        // even parity: 0x03 has two ones, so parity bit 1 is wrong, 0 is right
        send_frame(1, 8'h03, 1'b1, 1'b1);
        pop_word(1, "par_bad_03", 11'h103);
        send_frame(1, 8'h03, 1'b1, 1'b0);
        pop_word(1, "par_ok_03", 11'h003);

        // 0x5A with stop 0, line low 40 clocks, then high, then 0x3C
        d = 8'h5A;
        drive(0, 1'b0, CPB);
        for (int i = 0; i < 8; i++) drive(0, d[i], CPB);
        drive(0, 1'b0, 40);
        @(negedge clk);
        check("busy_wait_high", 32'(busy_a), 32'd1);
        drive(0, 1'b1, 20);
        @(negedge clk);
        check("busy_after_high", 32'(busy_a), 32'd0);
        pop_word(0, "frame_5a", 11'h25A);
        send_frame(0, 8'h3C, 1'b0, 1'b0);
        pop_word(0, "word_3c", 11'h03C);

        // false start: 4 low clocks
        drive(0, 1'b0, 4);
        @(negedge clk);
        check("busy_false_start", 32'(busy_a), 32'd1);
        drive(0, 1'b1, 30);
        @(negedge clk);
        check("idle_after_false", 32'(busy_a), 32'd0);
        check("no_word_false", 32'(got_a.size()), 32'd0);

        // 0x00 with a 1-clock high glitch at cnt=M of data bit 2
        drive(0, 1'b0, CPB);
        drive(0, 1'b0, 2 * CPB);
        drive(0, 1'b0, 7);
        drive(0, 1'b1, 1);
        drive(0, 1'b0, 8);
        drive(0, 1'b0, 5 * CPB);
        drive(0, 1'b1, 2 * CPB);
        pop_word(0, "glitch_00", 11'h000);

        // overrun: ready low, two words; first held, second dropped
        bus_a.rx_ready = 1'b0;
        o0 = ocnt_a;
        send_frame(0, 8'h11, 1'b0, 1'b0);
        send_frame(0, 8'h22, 1'b0, 1'b0);
        @(negedge clk);
        check("hold_data_11", 32'(bus_a.rx_data), 32'h11);
        check("hold_valid", 32'(bus_a.rx_valid), 32'd1);
        check("overrun_once", 32'(ocnt_a - o0), 32'd1);
        @(posedge clk); #1;
        bus_a.rx_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("valid_dropped", 32'(bus_a.rx_valid), 32'd0);
        pop_word(0, "accept_11", 11'h011);
        check("no_word_22", 32'(got_a.size()), 32'd0);

        // break: whole frame low
        drive(0, 1'b0, 10 * CPB);
        drive(0, 1'b1, 30);
        pop_word(0, "break_00", 11'h600);

        // reset during data bit 3 with the line low
        drive(0, 1'b0, CPB);
        drive(0, 1'b0, 3 * CPB);
        drive(0, 1'b0, 8);
        rst = 1'b1;
        drive(0, 1'b0, 2);
        rst = 1'b0;
        drive(0, 1'b0, 200);
        @(negedge clk);
        check("rst_low_busy", 32'(busy_a), 32'd0);
        check("rst_low_valid", 32'(bus_a.rx_valid), 32'd0);
        check("rst_low_noword", 32'(got_a.size()), 32'd0);
        drive(0, 1'b1, 30);
        send_frame(0, 8'h7E, 1'b0, 1'b0);
        pop_word(0, "after_rst_7e", 11'h07E);
        check("no_extra_word", 32'(got_a.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
